// File: rtl/fpa_controller.sv
// -----------------------------------------------------------------------------
// fpa_controller
//
// Sequencing FSM for the floating-point adder datapath. A start request steps
// the datapath through the operand load, the align/add stage and the
// normalization load. It then runs iterative normalization shifts and
// finishes with the result latch. It monitors the datapath exception flags
// and the normalization mantissa. The outcome (good result or error) is
// reported through a done/res_ack handshake that stays held until it is
// acknowledged.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   clr          asynchronous active-low reset
//   start        operation request, honoured only while ready=1
//   res_ack      result acknowledge, honoured only while done=1
//   mant         normalization-register mantissa from the datapath
//                (bit MANT_W-1 = carry, bit MANT_W-2 = hidden one)
//   add_except   add-stage exception flag
//   norm_except  normalization exception flag
//   load_en      operand register enable
//   add_en       add-stage register enable
//   norm_en      normalization register enable
//   norm_load    normalization mux select (1 = load from add stage)
//   shift_right  normalization shift direction (1 = right, 0 = left)
//   done_en      final result register enable
//   ready        idle, a start will be accepted
//   done         result or error available
//   err          operation ended in an exception (valid while done=1)
//   err_code     01 add exception, 10 norm exception, 11 shift timeout
//
// Every output is decoded from registered state only, so no input has a
// combinational path to any output.
// -----------------------------------------------------------------------------
module fpa_controller #(
    parameter int MANT_W     = 5,
    parameter int MAX_SHIFTS = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              res_ack,
    input  logic [MANT_W-1:0] mant,
    input  logic              add_except,
    input  logic              norm_except,
    output logic              load_en,
    output logic              add_en,
    output logic              norm_en,
    output logic              norm_load,
    output logic              shift_right,
    output logic              done_en,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(MAX_SHIFTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SHIFTS);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_ADD    = 4'd2;
    localparam logic [3:0] S_NLOAD  = 4'd3;
    localparam logic [3:0] S_NCHK   = 4'd4;
    localparam logic [3:0] S_NSHIFT = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;
    localparam logic [3:0] S_RESULT = 4'd7;
    localparam logic [3:0] S_EXCEPT = 4'd8;

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_ADD     = 2'b01;
    localparam logic [1:0] E_NORM    = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       code_q, code_d;

    // Top two mantissa bits: 1x = carry out (shift right), 01 = normalized,
    // 00 = leading zeros after cancellation (shift left).
    logic [1:0] mant_top;
    assign mant_top = mant[MANT_W-1 -: 2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    // A fresh operation starts with no error recorded.
                    code_d  = E_NONE;
                end
            end
            S_LOAD:  state_d = S_ADD;
            S_ADD:   state_d = S_NLOAD;
            S_NLOAD: begin
                cnt_d = '0;
                if (add_except) begin
                    state_d = S_EXCEPT;
                    code_d  = E_ADD;
                end else begin
                    state_d = S_NCHK;
                end
            end
            S_NCHK: begin
                // Priority order matters: a zero or already-normalized
                // mantissa finishes even if the shift budget is used up.
                if (norm_except) begin
                    state_d = S_EXCEPT;
                    code_d  = E_NORM;
                end else if (mant == '0) begin
                    state_d = S_DONE;
                end else if (mant_top == 2'b01) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_EXCEPT;
                    code_d  = E_TIMEOUT;
                end else if (mant_top[1]) begin
                    state_d = S_NSHIFT;
                    dir_d   = 1'b1;
                end else begin
                    state_d = S_NSHIFT;
                    dir_d   = 1'b0;
                end
            end
            S_NSHIFT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = S_NCHK;
            end
            S_DONE: begin
                code_d  = E_NONE;
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (res_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_EXCEPT: begin
                if (res_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            code_q  <= code_d;
        end
    end

    // Moore decode: the enables are one-hot by construction because each
    // is tied to a distinct state.
    assign ready       = (state_q == S_IDLE);
    assign load_en     = (state_q == S_LOAD);
    assign add_en      = (state_q == S_ADD);
    assign norm_en     = (state_q == S_NLOAD) || (state_q == S_NSHIFT);
    assign norm_load   = (state_q == S_NLOAD);
    assign shift_right = (state_q == S_NSHIFT) && dir_q;
    assign done_en     = (state_q == S_DONE);
    assign done        = (state_q == S_RESULT) || (state_q == S_EXCEPT);
    assign err         = (state_q == S_EXCEPT);
    assign err_code    = code_q;

endmodule

// File: tb/tb_fpa_controller.sv
// -----------------------------------------------------------------------------
// tb_fpa_controller
//
// Each test task pushes a cycle-by-cycle script into a scoreboard queue. Every
// entry holds the output vector the controller must present in that cycle and
// the stimulus to apply before the next rising edge. drain() pops the entries
// in order and compares the sampled outputs against them.
//
// The DUT is built with MAX_SHIFTS=2 so that the timeout path is reachable
// with a short held mantissa.
//
// Output vector layout:
//   {ready, load_en, add_en, norm_en, norm_load, shift_right, done_en,
//    done, err, err_code[1:0]}
// -----------------------------------------------------------------------------
module tb_fpa_controller;

    localparam int MW = 5;

    localparam logic [10:0] V_IDLE  = 11'b10000000000;
    localparam logic [10:0] V_LOAD  = 11'b01000000000;
    localparam logic [10:0] V_ADD   = 11'b00100000000;
    localparam logic [10:0] V_NLOAD = 11'b00011000000;
    localparam logic [10:0] V_NCHK  = 11'b00000000000;
    localparam logic [10:0] V_SHR   = 11'b00010100000;
    localparam logic [10:0] V_SHL   = 11'b00010000000;
    localparam logic [10:0] V_DONE  = 11'b00000010000;
    localparam logic [10:0] V_RES   = 11'b00000001000;
    localparam logic [10:0] V_EXC   = 11'b00000001100;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          res_ack = 1'b0;
    logic [MW-1:0] mant = '0;
    logic          add_except = 1'b0;
    logic          norm_except = 1'b0;
    logic          load_en, add_en, norm_en, norm_load, shift_right;
    logic          done_en, ready, done, err;
    logic [1:0]    err_code;
    logic [10:0]   obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [10:0]   exp;
        logic          st;
        logic          ack;
        logic          ae;
        logic          ne;
        logic [MW-1:0] m;
    } ent_t;

    ent_t sb_q[$];

    fpa_controller #(.MANT_W(MW), .MAX_SHIFTS(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .res_ack     (res_ack),
        .mant        (mant),
        .add_except  (add_except),
        .norm_except (norm_except),
        .load_en     (load_en),
        .add_en      (add_en),
        .norm_en     (norm_en),
        .norm_load   (norm_load),
        .shift_right (shift_right),
        .done_en     (done_en),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    assign obs = {ready, load_en, add_en, norm_en, norm_load, shift_right,
                  done_en, done, err, err_code};

    task automatic push(input logic [10:0] e, input logic s = 1'b0,
                        input logic a = 1'b0, input logic ae = 1'b0,
                        input logic ne = 1'b0, input logic [MW-1:0] m = '0);
        ent_t x;
        x.exp = e; x.st = s; x.ack = a; x.ae = ae; x.ne = ne; x.m = m;
        sb_q.push_back(x);
    endtask

    // Common opening: IDLE with start, then LOAD and ADD.
    task automatic push_head(input logic [1:0] idle_code);
        push(V_IDLE | 11'(idle_code), 1'b1);
        push(V_LOAD);
        push(V_ADD);
    endtask

    task automatic drain(input string name);
        int idx = 0;
        int errs0 = errors;
        while (sb_q.size() > 0) begin
            ent_t e = sb_q.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s c%0d: outputs=%b required=%b", name, idx, obs, e.exp);
            end
            start       = e.st;
            res_ack     = e.ack;
            add_except  = e.ae;
            norm_except = e.ne;
            mant        = e.m;
            if (sb_q.size() > 0) begin
                @(posedge clk);
                #1;
            end
            idx++;
        end
        start = 1'b0; res_ack = 1'b0; add_except = 1'b0; norm_except = 1'b0;
        $display("%s: %0d cycles compared, %0d errors", name, idx, errors - errs0);
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset: outputs=%b required=%b", obs, V_IDLE);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_release: outputs=%b required=%b", obs, V_IDLE);
        end
        $display("reset: checked");
    endtask

    task automatic test_no_shift();
        push_head(2'b00);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b01010);
        push(V_DONE);
        push(V_RES);
        push(V_RES);
        push(V_RES, 0, 1);
        push(V_IDLE);
        drain("no_shift");
    endtask

    task automatic test_carry_out();
        push_head(2'b00);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b10110);
        push(V_SHR);
        push(V_NCHK, 0, 0, 0, 0, 5'b01011);
        push(V_DONE);
        push(V_RES, 0, 1);
        push(V_IDLE);
        drain("carry_out");
    endtask

    task automatic test_cancellation();
        push_head(2'b00);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b00011);
        push(V_SHL);
        push(V_NCHK, 0, 0, 0, 0, 5'b00110);
        push(V_SHL);
        push(V_NCHK, 0, 0, 0, 0, 5'b01100);
        push(V_DONE);
        push(V_RES, 0, 1);
        push(V_IDLE);
        drain("cancellation");
    endtask

    task automatic test_timeout();
        push_head(2'b00);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b00001);
        push(V_SHL);
        push(V_NCHK, 0, 0, 0, 0, 5'b00001);
        push(V_SHL);
        push(V_NCHK, 0, 0, 0, 0, 5'b00001);
        push(V_EXC | 11'b11);
        push(V_EXC | 11'b11);
        push(V_EXC | 11'b11, 0, 1);
        push(V_IDLE | 11'b11);
        drain("timeout");
    endtask

    task automatic test_add_except();
        push_head(2'b11);
        push(V_NLOAD, 0, 0, 1);
        for (int i = 0; i < 10; i++) push(V_EXC | 11'b01);
        push(V_EXC | 11'b01, 0, 1);
        push(V_IDLE | 11'b01);
        drain("add_except");
    endtask

    task automatic test_norm_except();
        push_head(2'b01);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 1, 5'b01010);
        for (int i = 0; i < 10; i++) push(V_EXC | 11'b10);
        push(V_EXC | 11'b10, 0, 1);
        push(V_IDLE | 11'b10);
        drain("norm_except");
    endtask

    task automatic test_back_to_back();
        // Stray ack while busy, start during ADD, zero mantissa, and
        // start together with ack in RESULT.
        push(V_IDLE | 11'b10, 1);
        push(V_LOAD, 0, 1);
        push(V_ADD, 1);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b00000);
        push(V_DONE);
        push(V_RES, 1, 1);
        push(V_IDLE);
        push(V_IDLE);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid_shift();
        push_head(2'b00);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b00011);
        push(V_SHL);
        drain("reset_mid_shift");
        #1;
        clr = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL async_reset: outputs=%b required=%b", obs, V_IDLE);
        end
        @(posedge clk);
        #1;
        clr = 1'b1;
        push_head(2'b00);
        push(V_NLOAD);
        push(V_NCHK, 0, 0, 0, 0, 5'b01111);
        push(V_DONE);
        push(V_RES, 0, 1);
        push(V_IDLE);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_no_shift();
        test_carry_out();
        test_cancellation();
        test_timeout();
        test_add_except();
        test_norm_except();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
